// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Byte-addressable, little-endian data RAM for the memory stage. Accepts one
//   request per cycle over a valid/ready port and returns a registered
//   response one cycle after acceptance. Word/half/byte stores use per-byte
//   lane enables. Loads are sign- or zero-extended. Misaligned and
//   out-of-range accesses are flagged and have no side effect on the array.
//   After reset, the array is optionally cleared one word per cycle.
//
// Ports
//   CLK           clock, rising edge
//   RST           asynchronous active-low reset
//   req_valid     request present
//   req_ready     block can accept a request this cycle
//   req_we        1 = store, 0 = load
//   req_size      00 word, 01 half, 10/11 byte
//   req_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data (low bytes used for half/byte)
//   rsp_valid     one-cycle pulse, response to the previous cycle's request
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_err       misaligned or out-of-range access
//   init_done     high once the post-reset clear has finished
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;

  // Response metadata captured at the accept edge
  logic              rsp_zero;
  logic [1:0]        rsp_size;
  logic              rsp_unsigned;
  logic [1:0]        rsp_lane;

  // Request decode
  logic              accept;
  logic              addr_oor;
  logic              addr_mis;
  logic              req_err;
  logic              st_we;
  logic              clr_we;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [IDX_W-1:0]  req_idx;

  always_comb begin
    accept   = req_valid & req_ready;
    req_idx  = req_addr[ADDR_WIDTH-1:2];
    addr_oor = |req_addr[31:ADDR_WIDTH];
    case (req_size)
      2'b00:   addr_mis = |req_addr[1:0];
      2'b01:   addr_mis = req_addr[0];
      default: addr_mis = 1'b0;
    endcase
    req_err = addr_oor | addr_mis;
    st_we   = accept & req_we & ~req_err;
    clr_we  = (state == S_CLEAR);

    // Store data is replicated across lanes so the enables alone pick the bytes
    case (req_size)
      2'b00: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
      2'b01: begin
        st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
    endcase
  end

  // Array: not reset; cleared by the CLEAR state. A store on edge N is
  // visible to a read on edge N+1, so back-to-back store/load is coherent.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (st_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem[req_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
    if (accept) begin
      rd_word <= mem[req_idx];
    end
  end

  // Control FSM and response registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_idx      <= '0;
      req_ready    <= 1'b0;
      init_done    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_zero     <= 1'b1;
      rsp_size     <= 2'b00;
      rsp_unsigned <= 1'b0;
      rsp_lane     <= 2'b00;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err      <= req_err;
        rsp_zero     <= req_we | req_err;
        rsp_size     <= req_size;
        rsp_unsigned <= req_unsigned;
        rsp_lane     <= req_addr[1:0];
      end
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Lane select and extension on the registered word. Everything feeding
  // this only changes on an accept, so rsp_rdata holds between responses.
  logic [15:0] sel_half;
  logic [7:0]  sel_byte;

  always_comb begin
    sel_half = rsp_lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (rsp_lane)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    rsp_rdata = '0;
    if (!rsp_zero) begin
      case (rsp_size)
        2'b00:   rsp_rdata = rd_word;
        2'b01:   rsp_rdata = {{16{sel_half[15] & ~rsp_unsigned}}, sel_half};
        default: rsp_rdata = {{24{sel_byte[7] & ~rsp_unsigned}}, sel_byte};
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int unsigned AW    = 6;
  localparam int unsigned BYTES = 1 << AW;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  data_mem_ctrl #(
    .ADDR_WIDTH     (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: plain byte array, little endian
  logic [7:0]  mbytes [BYTES];
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(BYTES); i++) mbytes[i] = 8'h00;
  endtask

  task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] data);
    int unsigned nb;
    int unsigned a;
    logic [31:0] ones;
    ones = '1;
    nb = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    err = (addr >= BYTES) || (addr % nb != 0);
    data = 32'h0;
    a = addr;
    if (!err) begin
      if (we) begin
        for (int unsigned k = 0; k < nb; k++) mbytes[a + k] = wdata[8*k +: 8];
      end else begin
        for (int unsigned k = 0; k < nb; k++) data = data | (32'(mbytes[a + k]) << (8*k));
        if (!uns && nb < 4 && data[8*nb-1]) data = data | (ones << (8*nb));
      end
    end
  endtask

  // Present one request at posedge+1, sample the response at next posedge+1
  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic        e_err;
    logic [31:0] e_data;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    model_access(we, size, uns, addr, wdata, e_err, e_data);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".err"}, 32'(rsp_err), 32'(e_err));
    check({tag, ".rdata"}, rsp_rdata, e_data);
    last_rdata = e_data;
    last_err = e_err;
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    @(posedge CLK); #1;
    check({tag, ".valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".hold_rdata"}, rsp_rdata, last_rdata);
    check({tag, ".hold_err"}, 32'(rsp_err), 32'(last_err));
  endtask

  // Release reset and walk through CLEAR with req_valid held high
  task automatic release_and_clear(input string tag);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
    RST = 1'b1;
    check({tag, ".ready0"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      check({tag, ".clr_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".clr_rsp"}, 32'(rsp_valid), 32'd0);
      check({tag, ".clr_done"}, 32'(init_done), 32'd0);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check({tag, ".ready_up"}, 32'(req_ready), 32'd1);
    check({tag, ".init_done"}, 32'(init_done), 32'd1);
    check({tag, ".no_rsp"}, 32'(rsp_valid), 32'd0);
    model_clear();
    last_rdata = 32'h0;
    last_err = 1'b0;
    idle({tag, ".after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;

    RST = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    last_rdata = '0; last_err = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.init_done", 32'(init_done), 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    check("rst.err", 32'(rsp_err), 32'd0);

    release_and_clear("clear1");

    req(1'b0, 2'b00, 1'b0, 32'h3C, 32'h0, "lw_3c");
    check("lw_3c.const", last_rdata, 32'h0);

    // Back-to-back word store and loads
    req(1'b1, 2'b00, 1'b0, 32'h08, 32'h11223344, "sw_08");
    req(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, "lw_08");
    check("lw_08.const", rsp_rdata, 32'h11223344);
    req(1'b0, 2'b10, 1'b0, 32'h09, 32'h0, "lb_09");
    check("lb_09.const", rsp_rdata, 32'h00000033);
    req(1'b1, 2'b10, 1'b0, 32'h0A, 32'h000000F0, "sb_0a");
    req(1'b0, 2'b10, 1'b0, 32'h0A, 32'h0, "lb_0a");
    check("lb_0a.const", rsp_rdata, 32'hFFFFFFF0);
    req(1'b0, 2'b10, 1'b1, 32'h0A, 32'h0, "lbu_0a");
    check("lbu_0a.const", rsp_rdata, 32'h000000F0);
    req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, "lh_0a");
    check("lh_0a.const", rsp_rdata, 32'h000011F0);
    req(1'b1, 2'b01, 1'b0, 32'h08, 32'h00008001, "sh_08");
    req(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, "lw_08b");
    check("lw_08b.const", rsp_rdata, 32'h11F08001);
    req(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, "lh_08");
    check("lh_08.const", rsp_rdata, 32'hFFFF8001);
    idle("idle1");

    // Errors
    req(1'b1, 2'b00, 1'b0, 32'h04, 32'hCAFEF00D, "sw_04");
    req(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, "lw_06");
    check("lw_06.err_const", 32'(rsp_err), 32'd1);
    req(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000FFFF, "sh_05");
    check("sh_05.err_const", 32'(rsp_err), 32'd1);
    req(1'b0, 2'b00, 1'b0, 32'h04, 32'h0, "lw_04");
    check("lw_04.const", rsp_rdata, 32'hCAFEF00D);
    req(1'b1, 2'b00, 1'b0, 32'(BYTES), 32'h55AA55AA, "sw_oor");
    check("sw_oor.err_const", 32'(rsp_err), 32'd1);
    req(1'b0, 2'b00, 1'b0, 32'h00, 32'h0, "lw_00_nowrap");
    check("lw_00.const", rsp_rdata, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, "lb_oor_hi");
    idle("idle2");

    // Size 11 behaves as byte
    req(1'b1, 2'b11, 1'b0, 32'h21, 32'hABCDEF5A, "s11_21");
    req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, "lw_20");
    check("lw_20.const", rsp_rdata, 32'h00005A00);
    req(1'b0, 2'b11, 1'b1, 32'h21, 32'h0, "l11u_21");

    // Randomized traffic against the byte model
    for (int i = 0; i < 300; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) r_addr = $urandom();
      else                           r_addr = 32'($urandom_range(0, BYTES - 1));
      req(r_we, r_size, 1'($urandom_range(0, 1)), r_addr, $urandom(), "rand");
      if ($urandom_range(0, 4) == 0) idle("rand_idle");
    end

    // Async reset between accept and response
    req(1'b1, 2'b00, 1'b0, 32'h08, 32'h11223344, "sw_08c");
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h08; req_wdata = '0;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("inflight.valid", 32'(rsp_valid), 32'd1);
    RST = 1'b0;
    #1;
    check("midrst.valid", 32'(rsp_valid), 32'd0);
    check("midrst.ready", 32'(req_ready), 32'd0);
    check("midrst.init_done", 32'(init_done), 32'd0);
    @(posedge CLK); #1;
    check("midrst.valid2", 32'(rsp_valid), 32'd0);
    release_and_clear("clear2");
    req(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, "lw_08_recleared");
    check("lw_08_recleared.const", rsp_rdata, 32'h0);
    req(1'b0, 2'b00, 1'b0, 32'h04, 32'h0, "lw_04_recleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, byte-addressable, little-endian data memory with a valid/ready request port and a registered response port. Supports word, half and byte stores, plus sign- or zero-extending loads. Detects misaligned and out-of-range accesses, and clears its array sequentially after reset. Sits on the MIPS datapath's memory stage as the next-generation data RAM.

Parameters:
ADDR_WIDTH, 12, byte-address bits actually decoded; capacity = 2**ADDR_WIDTH bytes, DEPTH = 2**(ADDR_WIDTH-2) 32-bit words
CLEAR_ON_RESET, 1, 1 = run the CLEAR state after reset; 0 = go straight to IDLE (array contents undefined)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 half, 10 byte, 11 treated as byte
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data; low bytes used for half/byte
rsp_valid  out  1  one-cycle pulse, response for the request accepted the previous cycle
rsp_rdata  out  32  load data after extension; 0 for stores and errors
rsp_err  out  1  qualifies rsp_valid: misaligned or out-of-range access
init_done  out  1  high once CLEAR has finished

Behaviour:
- Reset (RST low, async): state=CLEAR (or IDLE if CLEAR_ON_RESET=0), clear counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0 (1 if CLEAR_ON_RESET=0, from the first edge after release). Array is not reset directly.
- Storage: DEPTH x 32-bit words with per-byte write enables. Word index = req_addr[ADDR_WIDTH-1:2]. Byte lane = req_addr[1:0]. Byte 0 is bits [7:0] (little endian).
- FSM state CLEAR: one word written to 0 per cycle, index 0..DEPTH-1. Takes exactly DEPTH cycles after reset release, then moves to IDLE and sets init_done=1.
- FSM state IDLE: req_ready=1. Transfer occurs when req_valid && req_ready. Requests with req_valid high during CLEAR are ignored (not queued).
- Latency: request accepted on edge N gives rsp_valid=1 for the cycle after edge N. Back-to-back requests every cycle are allowed, with full throughput. There is no response backpressure.
- Error check, evaluated at acceptance, in priority order:
  - out-of-range: req_addr[31:ADDR_WIDTH] != 0.
  - misaligned: word with addr[1:0] != 0, or half with addr[0] != 0.
  - On error: no array write, rsp_err=1, rsp_rdata=0.
- Store: enables byte lanes as follows.
  - word: lanes 3..0 <- wdata[31:0].
  - half: lanes {a+1,a} <- wdata[15:0], a = addr[1:0] in {0,2}.
  - byte: lane a <- wdata[7:0].
  - Response: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Load: the word is read synchronously at the accept edge. Lane select and extension are applied to the registered word.
  - word: full word.
  - half: the lane pair, extended from bit 15.
  - byte: the lane, extended from bit 7.
  - req_unsigned forces zero-extension; it is ignored for word.
- Ordering: a load accepted on edge N+1 returns data including a store accepted on edge N to the same word. No stale read is permitted.
- rsp_rdata and rsp_err hold their last values while rsp_valid=0.
- Reset mid-CLEAR or mid-transfer: the in-flight response is dropped (rsp_valid=0 immediately) and CLEAR restarts from index 0.

Test Plan:
- Reset/clear, ADDR_WIDTH=6: release RST -> req_ready=0 for 16 cycles, then init_done=1. LW at 0x3C returns 0x00000000, err=0.
- Word store/load: SW 0x11223344 @0x8, then LW @0x8 next cycle -> rsp 0x11223344 one cycle after accept, back-to-back with no bubble.
- Sub-word extension: after the store above:
  - LB @0x9 -> 0x00000033.
  - SB 0xF0 @0xA, then LB @0xA -> 0xFFFFFFF0; LBU -> 0x000000F0.
  - LH @0xA -> 0x000011F0.
  - SH 0x8001 @0x8, then LW -> 0x11F08001.
- Errors: LW @0x6 -> err=1, rdata=0. SH @0x5 -> err=1 and a later LW @0x4 is unchanged. SW @(2**ADDR_WIDTH) -> err=1, no array wrap.
- Handshake: req_valid held high during CLEAR -> no response. Size=11 store -> byte behaviour.
- Async reset mid-stream: assert RST between accept and response -> rsp_valid=0 immediately, no response after release, array re-cleared (previous 0x11223344 now reads 0).
